// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED pattern generator (optional feature macro: LED_PHASE_SYNC_EN)
module led_pattern_gen #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 26,
    parameter int DEF_HALF = 50000000
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [4:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
`ifdef LED_PHASE_SYNC_EN
    input  logic              sync,
`endif
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] done
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_DEF = CNT_W'(DEF_HALF);

    mode_t            mode_q [NUM_CH];
    mode_t            mode_d [NUM_CH];
    logic [CNT_W-1:0] half_q [NUM_CH];
    logic [CNT_W-1:0] half_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q  [NUM_CH];
    logic [CNT_W-1:0] cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] led_q, led_d;
    logic [NUM_CH-1:0] done_q, done_d;

    logic             wr_hit;
    logic [CNT_W-1:0] wr_half;
    mode_t            wr_mode;

    assign led  = led_q;
    assign done = done_q;

    // Channel state registers; reset leaves every channel blinking at the default rate.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_BLINK;
                half_q[i] <= HALF_DEF;
                cnt_q[i]  <= CNT_ONE;
            end
            led_q  <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= mode_d[i];
                half_q[i] <= half_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            led_q  <= led_d;
            done_q <= done_d;
        end
    end

    // Per-channel next state: a write beats sync, which beats the terminal-count action.
    always_comb begin
        wr_hit  = 1'b0;
        wr_mode = mode_t'(cfg_mode);
        wr_half = (cfg_half == '0) ? CNT_ONE : cfg_half;
        led_d   = led_q;
        done_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i] = mode_q[i];
            half_d[i] = half_q[i];
            cnt_d[i]  = cnt_q[i];
            wr_hit    = cfg_we && (int'(cfg_ch) == i);
            if (wr_hit) begin
                mode_d[i] = wr_mode;
                half_d[i] = wr_half;
                cnt_d[i]  = CNT_ONE;
                led_d[i]  = (wr_mode == MODE_ON) || (wr_mode == MODE_ONESHOT);
            end
`ifdef LED_PHASE_SYNC_EN
            else if (sync && (mode_q[i] == MODE_BLINK)) begin
                cnt_d[i] = CNT_ONE;
                led_d[i] = 1'b0;
            end
`endif
            else begin
                case (mode_q[i])
                    MODE_OFF: begin
                        cnt_d[i] = CNT_ONE;
                        led_d[i] = 1'b0;
                    end
                    MODE_ON: begin
                        cnt_d[i] = CNT_ONE;
                        led_d[i] = 1'b1;
                    end
                    MODE_BLINK: begin
                        if (cnt_q[i] == half_q[i]) begin
                            cnt_d[i] = CNT_ONE;
                            led_d[i] = ~led_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        if (cnt_q[i] == half_q[i]) begin
                            cnt_d[i]  = CNT_ONE;
                            led_d[i]  = 1'b0;
                            mode_d[i] = MODE_OFF;
                            done_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - randomized self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int DEF_HALF = 4;

    logic              clk_in = 1'b0;
    logic              reset_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [4:0]        cfg_ch = '0;
    logic [1:0]        cfg_mode = '0;
    logic [CNT_W-1:0]  cfg_half = '0;
`ifdef LED_PHASE_SYNC_EN
    logic              sync = 1'b0;
`endif
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] done;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model: each channel is described by its last (re)start edge, mode and half.
    int m_mode [NUM_CH];
    int m_half [NUM_CH];
    int m_k    [NUM_CH];

    led_pattern_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
`ifdef LED_PHASE_SYNC_EN
        .sync     (sync),
`endif
        .led      (led),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic exp_led(input int ch);
        int d;
        d = cycle - m_k[ch];
        case (m_mode[ch])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((d / m_half[ch]) % 2) == 1;
            default: return d < m_half[ch];
        endcase
    endfunction

    function automatic logic exp_done(input int ch);
        return (m_mode[ch] == 3) && ((cycle - m_k[ch]) == m_half[ch]);
    endfunction

    task automatic model_reset_release();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 2;
            m_half[c] = DEF_HALF;
            m_k[c]    = cycle;
        end
    endtask

    task automatic step(input logic we, input int ch, input int mode, input int half, input logic sy);
        logic [NUM_CH-1:0] el, ed;
        cfg_we   = we;
        cfg_ch   = ch[4:0];
        cfg_mode = mode[1:0];
        cfg_half = CNT_W'(half);
`ifdef LED_PHASE_SYNC_EN
        sync     = sy;
`endif
        @(posedge clk_in);
        cycle++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (we && ch == c) begin
                m_mode[c] = mode;
                m_half[c] = (half == 0) ? 1 : half;
                m_k[c]    = cycle;
            end else if (sy && m_mode[c] == 2) begin
                m_k[c] = cycle;
            end
        end
        #1;
        cfg_we = 1'b0;
`ifdef LED_PHASE_SYNC_EN
        sync   = 1'b0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            el[c] = exp_led(c);
            ed[c] = exp_done(c);
        end
        checks++;
        if (led !== el) begin
            errors++;
            $display("FAIL led cycle=%0d actual=%b required=%b", cycle, led, el);
        end
        checks++;
        if (done !== ed) begin
            errors++;
            $display("FAIL done cycle=%0d actual=%b required=%b", cycle, done, ed);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) begin
            @(posedge clk_in);
            cycle++;
        end
        #1;
        checks++;
        if (led !== '0 || done !== '0) begin
            errors++;
            $display("FAIL reset_state actual=%b/%b required=0000/0000", led, done);
        end
        reset_n = 1'b1;
        model_reset_release();
        idle(20);
    endtask

    task automatic test_blink_on();
        step(1'b1, 1, 2, 2, 1'b0);
        step(1'b1, 2, 1, 3, 1'b0);
        idle(12);
    endtask

    task automatic test_oneshot_restart();
        int hi, pulses;
        hi = 0;
        pulses = 0;
        step(1'b1, 3, 3, 5, 1'b0);
        hi += led[3];
        for (int j = 0; j < 2; j++) begin
            step(1'b0, 0, 0, 0, 1'b0);
            hi += led[3];
            pulses += done[3];
        end
        step(1'b1, 3, 3, 5, 1'b0);
        hi += led[3];
        pulses += done[3];
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 0, 0, 0, 1'b0);
            hi += led[3];
            pulses += done[3];
        end
        checks++;
        if (hi !== 8) begin
            errors++;
            $display("FAIL oneshot_high_cycles actual=%0d required=8", hi);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL oneshot_done_pulses actual=%0d required=1", pulses);
        end
    endtask

    task automatic test_half_zero_bad_ch();
        step(1'b1, 0, 2, 0, 1'b0);
        idle(6);
        step(1'b1, 7, 1, 3, 1'b0);
        idle(6);
    endtask

    task automatic test_write_at_terminal();
        step(1'b1, 1, 2, 3, 1'b0);
        idle(2);
        step(1'b1, 1, 2, 3, 1'b0);
        checks++;
        if (led[1] !== 1'b0) begin
            errors++;
            $display("FAIL write_at_terminal actual=%b required=0", led[1]);
        end
        idle(8);
    endtask

    task automatic test_async_reset();
        step(1'b1, 2, 3, 6, 1'b0);
        idle(2);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (led !== '0 || done !== '0) begin
            errors++;
            $display("FAIL async_reset actual=%b/%b required=0000/0000", led, done);
        end
        @(posedge clk_in);
        cycle++;
        #1;
        reset_n = 1'b1;
        model_reset_release();
        idle(10);
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 6)), 1'b0);
            else
                step(1'b0, 0, 0, 0, 1'b0);
        end
    endtask

`ifdef LED_PHASE_SYNC_EN
    task automatic test_sync();
        step(1'b1, 0, 2, 3, 1'b0);
        step(1'b1, 1, 2, 5, 1'b0);
        idle(4);
        step(1'b0, 0, 0, 0, 1'b1);
        checks++;
        if (led[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL sync_align actual=%b required=00", led[1:0]);
        end
        idle(7);
        step(1'b1, 1, 3, 4, 1'b1);
        checks++;
        if (led[1] !== 1'b1) begin
            errors++;
            $display("FAIL sync_vs_write actual=%b required=1", led[1]);
        end
        idle(8);
    endtask
`endif

    initial begin
        test_reset();
        test_blink_on();
        test_oneshot_restart();
        test_half_zero_bad_ch();
        test_write_at_terminal();
        test_async_reset();
`ifdef LED_PHASE_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
